// File: rtl/rggen_apb_register_adapter.sv
// -----------------------------------------------------------------------------
// rggen_apb_register_adapter
//
// Converts an APB3/APB4 slave access into the register-access bundle that is
// broadcast to every register instance of a block, then collects the
// per-register responses and returns pready/prdata/pslverr to the APB master.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_psel .. i_pwdata       APB slave request (i_pprot is accepted but unused)
//   o_pready/o_prdata/o_pslverr   APB slave response, registered
//   o_register_*             access bundle to all registers (valid, access,
//                            address, write_data, strobe), registered
//   i_register_*             per-register active/ready/status/read_data,
//                            concatenated with register 0 in the low slice
//
// Transfer: IDLE latches the setup phase, BUSY holds valid until a register
// answers (or nobody claims the address), ACK pulses pready for one cycle.
// -----------------------------------------------------------------------------
module rggen_apb_register_adapter #(
    parameter int                       ADDRESS_WIDTH       = 8,
    parameter int                       LOCAL_ADDRESS_WIDTH = 8,
    parameter int                       BUS_WIDTH           = 32,
    parameter int                       REGISTERS           = 1,
    parameter bit                       PRE_DECODE          = 1'b0,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
    parameter bit                       ERROR_STATUS        = 1'b0,
    parameter logic [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_psel,
    input  logic                           i_penable,
    input  logic [ADDRESS_WIDTH-1:0]       i_paddr,
    input  logic [2:0]                     i_pprot,
    input  logic                           i_pwrite,
    input  logic [BUS_WIDTH/8-1:0]         i_pstrb,
    input  logic [BUS_WIDTH-1:0]           i_pwdata,
    output logic                           o_pready,
    output logic [BUS_WIDTH-1:0]           o_prdata,
    output logic                           o_pslverr,
    output logic                           o_register_valid,
    output logic [1:0]                     o_register_access,
    output logic [ADDRESS_WIDTH-1:0]       o_register_address,
    output logic [BUS_WIDTH-1:0]           o_register_write_data,
    output logic [BUS_WIDTH/8-1:0]         o_register_strobe,
    input  logic [REGISTERS-1:0]           i_register_active,
    input  logic [REGISTERS-1:0]           i_register_ready,
    input  logic [2*REGISTERS-1:0]         i_register_status,
    input  logic [BUS_WIDTH*REGISTERS-1:0] i_register_read_data
);

    localparam int STRB_W = BUS_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);

    // Decode window computed one bit wider so BASE + span cannot wrap.
    localparam logic [ADDRESS_WIDTH:0] RANGE_LO   = {1'b0, BASE_ADDRESS};
    localparam logic [ADDRESS_WIDTH:0] RANGE_SPAN = (ADDRESS_WIDTH+1)'(1) << LOCAL_ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH:0] RANGE_HI   = RANGE_LO + RANGE_SPAN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e                     state_q;
    logic                       valid_q;
    logic [1:0]                 access_q;
    logic [ADDRESS_WIDTH-1:0]   address_q;
    logic [BUS_WIDTH-1:0]       write_data_q;
    logic [STRB_W-1:0]          strobe_q;
    logic                       pready_q;
    logic [BUS_WIDTH-1:0]       prdata_q;
    logic                       pslverr_q;

    logic                       in_range;
    logic [ADDRESS_WIDTH:0]     paddr_ext;
    logic                       any_active;
    logic                       any_ready;
    logic [1:0]                 merged_status;
    logic [BUS_WIDTH-1:0]       merged_data;
    logic [1:0]                 resp_status;
    logic [BUS_WIDTH-1:0]       resp_data;
    logic                       unused_pprot;

    // Protection attributes carry no meaning for register access.
    assign unused_pprot = ^i_pprot;

    assign paddr_ext = {1'b0, i_paddr};
    assign in_range  = !PRE_DECODE || ((paddr_ext >= RANGE_LO) && (paddr_ext < RANGE_HI));

    // Responses are OR-merged over every register signalling ready; more than
    // one ready at a time is illegal and is merged without being flagged.
    always_comb begin
        any_active    = |i_register_active;
        any_ready     = |i_register_ready;
        merged_status = '0;
        merged_data   = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (i_register_ready[i]) begin
                merged_status = merged_status | i_register_status[2*i +: 2];
                merged_data   = merged_data | i_register_read_data[BUS_WIDTH*i +: BUS_WIDTH];
            end
        end
        // Nobody claimed the address: answer locally with a decode error.
        resp_status = any_active ? merged_status : 2'b11;
        resp_data   = any_active ? merged_data : DEFAULT_READ_DATA;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            access_q     <= '0;
            address_q    <= '0;
            write_data_q <= '0;
            strobe_q     <= '0;
            pready_q     <= 1'b0;
            prdata_q     <= '0;
            pslverr_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                    if (i_psel && !i_penable) begin
                        access_q     <= {1'b1, i_pwrite};
                        address_q    <= {i_paddr[ADDRESS_WIDTH-1:LSB], {LSB{1'b0}}};
                        write_data_q <= i_pwrite ? i_pwdata : '0;
                        strobe_q     <= i_pwrite ? i_pstrb : '1;
                        if (!in_range) begin
                            // Pre-decode miss: registers never see the access.
                            state_q   <= ACK;
                            pready_q  <= 1'b1;
                            pslverr_q <= ERROR_STATUS;
                            prdata_q  <= i_pwrite ? '0 : DEFAULT_READ_DATA;
                        end else begin
                            state_q <= BUSY;
                            valid_q <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (!any_active || any_ready) begin
                        state_q   <= ACK;
                        valid_q   <= 1'b0;
                        pready_q  <= 1'b1;
                        pslverr_q <= ERROR_STATUS & resp_status[1];
                        prdata_q  <= access_q[0] ? '0 : resp_data;
                    end
                end
                ACK: begin
                    state_q   <= IDLE;
                    pready_q  <= 1'b0;
                    prdata_q  <= '0;
                    pslverr_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    valid_q  <= 1'b0;
                    pready_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_pready              = pready_q;
    assign o_prdata              = prdata_q;
    assign o_pslverr             = pslverr_q;
    assign o_register_valid      = valid_q;
    assign o_register_access     = access_q;
    assign o_register_address    = address_q;
    assign o_register_write_data = write_data_q;
    assign o_register_strobe     = strobe_q;

endmodule

// File: tb/tb_rggen_apb_register_adapter.sv
// -----------------------------------------------------------------------------
// tb_rggen_apb_register_adapter
//
// Drives APB transfers into two adapter instances sharing the same inputs:
// dut_a decodes a 256-byte window at 0x100 and reports errors, dut_b has no
// pre-decode and never reports errors. The bench plays the role of four
// word registers at 0x100..0x10C backed by a small memory model, with a
// chosen ready delay and status per transfer.
// -----------------------------------------------------------------------------
module tb_rggen_apb_register_adapter;

    localparam int                AW  = 16;
    localparam int                BW  = 32;
    localparam int                NR  = 4;
    localparam logic [BW-1:0]     DEF = 32'hBAD0_F00D;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             psel, penable, pwrite;
    logic [AW-1:0]    paddr;
    logic [2:0]       pprot;
    logic [BW/8-1:0]  pstrb;
    logic [BW-1:0]    pwdata;
    logic [NR-1:0]    active, ready;
    logic [2*NR-1:0]  status;
    logic [BW*NR-1:0] rdata;

    logic             pready_a, pslverr_a, valid_a;
    logic [BW-1:0]    prdata_a, wdata_a;
    logic [1:0]       access_a;
    logic [AW-1:0]    address_a;
    logic [BW/8-1:0]  strobe_a;

    logic             pready_b, pslverr_b, valid_b;
    logic [BW-1:0]    prdata_b, wdata_b;
    logic [1:0]       access_b;
    logic [AW-1:0]    address_b;
    logic [BW/8-1:0]  strobe_b;

    always #5 clk = ~clk;

    rggen_apb_register_adapter #(
        .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(BW), .REGISTERS(NR),
        .PRE_DECODE(1'b1), .BASE_ADDRESS(16'h0100), .ERROR_STATUS(1'b1),
        .DEFAULT_READ_DATA(DEF)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable),
        .i_paddr(paddr), .i_pprot(pprot), .i_pwrite(pwrite), .i_pstrb(pstrb),
        .i_pwdata(pwdata), .o_pready(pready_a), .o_prdata(prdata_a),
        .o_pslverr(pslverr_a), .o_register_valid(valid_a),
        .o_register_access(access_a), .o_register_address(address_a),
        .o_register_write_data(wdata_a), .o_register_strobe(strobe_a),
        .i_register_active(active), .i_register_ready(ready),
        .i_register_status(status), .i_register_read_data(rdata)
    );

    rggen_apb_register_adapter #(
        .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(BW), .REGISTERS(NR),
        .PRE_DECODE(1'b0), .BASE_ADDRESS(16'h0000), .ERROR_STATUS(1'b0),
        .DEFAULT_READ_DATA(DEF)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable),
        .i_paddr(paddr), .i_pprot(pprot), .i_pwrite(pwrite), .i_pstrb(pstrb),
        .i_pwdata(pwdata), .o_pready(pready_b), .o_prdata(prdata_b),
        .o_pslverr(pslverr_b), .o_register_valid(valid_b),
        .o_register_access(access_b), .o_register_address(address_b),
        .o_register_write_data(wdata_b), .o_register_strobe(strobe_b),
        .i_register_active(active), .i_register_ready(ready),
        .i_register_status(status), .i_register_read_data(rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [BW-1:0] mem [NR];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic clear_regs();
        active = '0;
        ready  = '0;
        status = '0;
        rdata  = '0;
    endtask

    // Entered and left #1 after a rising edge with both adapters idle.
    task automatic do_xfer(input logic [AW-1:0] addr, input bit wr, input logic [BW-1:0] wd,
                           input logic [3:0] st, input int dly, input logic [1:0] stat,
                           input bit chk_b);
        int         off;
        bit         in_rng, mapped, done;
        int         r, vcnt, exp_vcnt;
        logic [BW-1:0] exp_rd;
        logic        exp_err;

        off    = int'(addr) - 256;
        in_rng = (addr >= 16'h0100) && (addr < 16'h0200);
        mapped = in_rng && ((off >> 2) < NR);
        r      = mapped ? (off >> 2) : 0;
        exp_vcnt = !in_rng ? 0 : (mapped ? dly + 1 : 1);
        exp_rd   = wr ? '0 : (mapped ? mem[r] : DEF);
        exp_err  = mapped ? stat[1] : 1'b1;

        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr;
        pwdata = wd; pstrb = st; pprot = 3'($urandom);
        @(posedge clk); #1;
        penable = 1'b1;
        vcnt = 0;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            clear_regs();
            if (pready_a) begin
                done = 1'b1;
            end else begin
                if (valid_a) begin
                    check("access", access_a, {1'b1, wr});
                    check("address", address_a, addr & 16'hFFFC);
                    check("write_data", wdata_a, wr ? wd : 32'h0);
                    check("strobe", strobe_a, wr ? st : 4'hF);
                    if (mapped) begin
                        active[r] = 1'b1;
                        rdata[r*BW +: BW] = mem[r];
                        if (vcnt == dly) begin
                            ready[r] = 1'b1;
                            status[2*r +: 2] = stat;
                        end
                    end
                    vcnt++;
                end
                @(posedge clk); #1;
            end
        end
        check("pready_timeout", done, 1'b1);
        if (done) begin
            check("valid_cycles", vcnt, exp_vcnt);
            check("valid_at_ack", valid_a, 1'b0);
            check("prdata", prdata_a, exp_rd);
            check("pslverr", pslverr_a, exp_err);
            if (chk_b) begin
                check("b_pready", pready_b, 1'b1);
                check("b_prdata", prdata_b, exp_rd);
                check("b_pslverr", pslverr_b, 1'b0);
            end
        end
        if (mapped && wr) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) mem[r][8*b +: 8] = wd[8*b +: 8];
        end
        @(posedge clk); #1;
        clear_regs();
        check("pready_one_cycle", pready_a, 1'b0);
        psel = 1'b0;
        penable = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] ra;
        int            sel;
        logic [1:0]    rs;

        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pprot = '0; pstrb = '0; pwdata = '0;
        clear_regs();
        mem[0] = 32'h0000_1111; mem[1] = 32'h2222_0000;
        mem[2] = 32'h1234_5678; mem[3] = 32'hCAFE_F00D;

        #2;
        check("rst_pready", pready_a, 1'b0);
        check("rst_prdata", prdata_a, 32'h0);
        check("rst_pslverr", pslverr_a, 1'b0);
        check("rst_valid", valid_a, 1'b0);
        check("rst_access", access_a, 2'b00);
        check("rst_strobe", strobe_a, 4'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Slave error from a register: only the error-reporting instance flags it.
        do_xfer(16'h010C, 1'b0, 32'h0, 4'h0, 1, 2'b10, 1'b1);
        // Write with partial strobe, ready in the first BUSY cycle.
        do_xfer(16'h0104, 1'b1, 32'hDEAD_BEEF, 4'b0011, 0, 2'b00, 1'b1);
        // Read that waits three BUSY cycles.
        do_xfer(16'h0108, 1'b0, 32'h0, 4'h0, 2, 2'b00, 1'b1);
        // Read back the partial write.
        do_xfer(16'h0104, 1'b0, 32'h0, 4'h0, 0, 2'b00, 1'b1);
        // In the window but unclaimed.
        do_xfer(16'h013C, 1'b0, 32'h0, 4'h0, 0, 2'b00, 1'b1);
        // Outside the pre-decode window.
        do_xfer(16'h0000, 1'b0, 32'h0, 4'h0, 0, 2'b00, 1'b0);

        // Reset while a register is stalling the access.
        repeat (3) begin @(posedge clk); #1; end
        psel = 1'b1; penable = 1'b0; paddr = 16'h0100; pwrite = 1'b0; pstrb = 4'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        active[0] = 1'b1;
        @(posedge clk); #1;
        check("busy_valid", valid_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", valid_a, 1'b0);
        check("mid_rst_pready", pready_a, 1'b0);
        check("mid_rst_prdata", prdata_a, 32'h0);
        check("mid_rst_access", access_a, 2'b00);
        check("mid_rst_address", address_a, 16'h0);
        clear_regs();
        psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_pready", pready_a, 1'b0);
        do_xfer(16'h0100, 1'b0, 32'h0, 4'h0, 1, 2'b00, 1'b1);

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)
                ra = 16'h0100 + 16'(4 * $urandom_range(0, NR - 1)) + 16'($urandom_range(0, 3));
            else if (sel == 7)
                ra = 16'h0110 + 16'($urandom_range(0, 16'hEF));
            else if ($urandom_range(0, 1) == 1)
                ra = 16'($urandom_range(0, 16'hFF));
            else
                ra = 16'($urandom_range(16'h0200, 16'hFFFF));
            case ($urandom_range(0, 4))
                3:       rs = 2'b10;
                4:       rs = 2'b11;
                default: rs = 2'b00;
            endcase
            do_xfer(ra, 1'($urandom_range(0, 1)), $urandom, 4'($urandom),
                    $urandom_range(0, 4), rs, 1'b0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
